pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Controls the system PLL's reset and monitors its lock output.
- Runs on the 50 MHz reference clock, which is valid before the PLL locks.
- Pulses the PLL reset, waits for lock with a timeout and bounded retries, then requires lock to hold for a stability window before releasing the downstream system reset.
- On loss of lock, re-asserts the system reset and restarts the PLL; it also reports status to software.

Parameters:
- RST_PULSE_CYCLES, 50, width of the PLL reset pulse in refclk cycles (1 us at 50 MHz); must be >= 1.
- LOCK_TIMEOUT_CYCLES, 50000, refclk cycles allowed in WAIT_LOCK before a retry.
- LOCK_STABLE_CYCLES, 1000, consecutive synchronized-locked cycles required before the system reset is released.
- MAX_RETRIES, 3, number of lock timeouts tolerated before entering FAIL; must be >= 1.
- GLITCH_CYCLES, 4, loss-of-lock filter length; used only when the optional feature is enabled.

Ports:
- refclk  in  1  reference clock; all logic is in this domain.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock output; asynchronous to refclk.
- relock_req  in  1  single-cycle request to restart the PLL; honoured in RUN and FAIL, ignored in all other states.
- pll_rst  out  1  reset to the PLL, active high.
- sys_rst  out  1  downstream system reset, active high.
- state  out  3  FSM state code: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAIL=4.
- retry_cnt  out  2  number of lock timeouts in the current bring-up attempt.
- fail  out  1  high while in FAIL.
- lock_lost_cnt  out  8  saturating count of lock losses detected in RUN.

Behaviour:
- Synchronizer: pll_locked passes through 2 flip-flops to form lk_s. The FSM uses only lk_s.
- Reset: when rst=1 at a clock edge:
  - state=RESET_PLL, pll_rst=1, sys_rst=1, fail=0.
  - retry_cnt=0, lock_lost_cnt=0, all counters=0, synchronizer flops=0.
  - rst applied mid-operation behaves identically, from any state.
- Outputs are registered. pll_rst=1 in RESET_PLL and FAIL only. sys_rst=0 in RUN only.
- RESET_PLL: count RST_PULSE_CYCLES cycles, then go to WAIT_LOCK. pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK: a counter starts at 0 on entry.
  - lk_s=1: go to STABILIZE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT_CYCLES-1: increment retry_cnt. If the new value equals MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL.
  - Lock wins if lk_s rises in the same cycle the timeout expires.
- STABILIZE: the stability counter starts at 0 on entry.
  - lk_s=0 at any point: return to WAIT_LOCK; the timeout counter restarts and retry_cnt is unchanged.
  - Counter reaches LOCK_STABLE_CYCLES-1 with lk_s=1: go to RUN, clear retry_cnt, and deassert sys_rst on the same edge.
- RUN:
  - A loss-of-lock event (lk_s=0): go to RESET_PLL, set sys_rst=1, and increment lock_lost_cnt (holds at 255).
  - Latency: sys_rst rises at the 3rd refclk edge after the first edge that samples pll_locked low (2 synchronizer flops + 1 state register).
  - relock_req=1: go to RESET_PLL with sys_rst=1; lock_lost_cnt is not incremented.
  - If loss of lock and relock_req occur together, it is treated as a loss of lock (counter increments).
- FAIL: pll_rst=1, sys_rst=1, fail=1. Leave only on rst, or on relock_req, which clears retry_cnt and goes to RESET_PLL.
- Counter widths: each counter is $clog2 of its limit, minimum 1 bit. Counters never wrap in normal operation because every terminal count forces a state change.

Optional Feature:
- Macro: PLL_SEQ_GLITCH_FILTER_EN.
- Defined: in RUN, loss of lock is declared only after lk_s=0 for GLITCH_CYCLES consecutive cycles. Any lk_s=1 cycle resets the filter count. sys_rst latency becomes GLITCH_CYCLES+2 edges.
- Not defined: a single lk_s=0 cycle in RUN triggers loss of lock. GLITCH_CYCLES is unused.
- WAIT_LOCK and STABILIZE behave the same in both builds.

Test Plan (RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, GLITCH_CYCLES=4):
- Normal bring-up: release rst, raise pll_locked 10 cycles later and hold it -> pll_rst high for exactly 4 cycles; state sequence 0 -> 1 -> 2 -> 3; sys_rst falls 8 cycles after STABILIZE entry; retry_cnt=0.
- Lock never asserts: hold pll_locked=0 -> two 4-cycle pll_rst pulses separated by 20-cycle waits; retry_cnt goes 1 then 2; state=4 and fail=1 with pll_rst and sys_rst held high. Then pulse relock_req -> state=0, retry_cnt=0.
- Unstable lock: in STABILIZE, drop pll_locked for 1 cycle after 5 stable cycles -> state returns to 1, sys_rst stays 1; after a later 8 stable cycles -> RUN.
- Loss of lock in RUN (filter disabled): drop pll_locked for 1 cycle -> sys_rst=1 at the 3rd edge; lock_lost_cnt=1; state=0. Repeat 300 times -> lock_lost_cnt saturates at 255.
- Filter enabled: a 3-cycle low on pll_locked in RUN -> no reaction. A 4-cycle low -> sys_rst=1 at edge 6 and state=0.
- Reset mid-operation: assert rst during STABILIZE and again during RUN -> the next edge gives state=0, pll_rst=1, sys_rst=1, all counters 0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the reference clock: pulses the PLL reset, waits for a stable lock, then releases the system reset.
// Optional loss-of-lock glitch filter in RUN: define PLL_SEQ_GLITCH_FILTER_EN.
//
//   state      | meaning
//   RESET_PLL  | pll_rst held high for RST_PULSE_CYCLES
//   WAIT_LOCK  | waiting for synchronized lock, timeout counts a retry
//   STABILIZE  | lock must hold LOCK_STABLE_CYCLES before release
//   RUN        | sys_rst released, watching for loss of lock
//   FAIL       | retries exhausted, waiting for relock_req or rst
module pll_reset_sequencer #(
   parameter int RST_PULSE_CYCLES    = 50,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1000,
   parameter int MAX_RETRIES         = 3,
   parameter int GLITCH_CYCLES       = 4
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic [2:0] state,
   output logic [1:0] retry_cnt,
   output logic       fail,
   output logic [7:0] lock_lost_cnt
);

   localparam int PW = (RST_PULSE_CYCLES > 1)    ? $clog2(RST_PULSE_CYCLES)    : 1;
   localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
   localparam int SW = (LOCK_STABLE_CYCLES > 1)  ? $clog2(LOCK_STABLE_CYCLES)  : 1;

   if (RST_PULSE_CYCLES < 1 || MAX_RETRIES < 1 || GLITCH_CYCLES < 1) begin : g_param_chk
      $error("pll_reset_sequencer: parameter out of range");
   end

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABILIZE = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic          lk_meta_q, lk_s_q;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic [1:0]    retry_q, retry_d;
   logic [7:0]    lost_q, lost_d;
   logic          pll_rst_q, sys_rst_q, fail_q;
   logic          loss_c;

`ifdef PLL_SEQ_GLITCH_FILTER_EN
   localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
   logic [GW-1:0] gcnt_q, gcnt_d;

   assign loss_c = (state_q == ST_RUN) && !lk_s_q && (gcnt_q == GW'(GLITCH_CYCLES - 1));

   always_comb begin
      gcnt_d = '0;
      if (state_q == ST_RUN && !lk_s_q && !loss_c) gcnt_d = gcnt_q + 1'b1;
   end

   always_ff @(posedge refclk) begin
      if (rst) gcnt_q <= '0;
      else     gcnt_q <= gcnt_d;
   end
`else
   assign loss_c = (state_q == ST_RUN) && !lk_s_q;
`endif

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      lost_d  = lost_q;
      case (state_q)
         ST_RESET_PLL: if (pcnt_q == PW'(RST_PULSE_CYCLES - 1)) state_d = ST_WAIT_LOCK;
         ST_WAIT_LOCK: begin
            // lock has priority over a timeout expiring on the same edge
            if (lk_s_q) begin
               state_d = ST_STABILIZE;
            end else if (tcnt_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
               retry_d = retry_q + 2'd1;
               state_d = (retry_d == 2'(MAX_RETRIES)) ? ST_FAIL : ST_RESET_PLL;
            end
         end
         ST_STABILIZE: begin
            if (!lk_s_q) begin
               state_d = ST_WAIT_LOCK;
            end else if (scnt_q == SW'(LOCK_STABLE_CYCLES - 1)) begin
               state_d = ST_RUN;
               retry_d = '0;
            end
         end
         ST_RUN: begin
            if (loss_c) begin
               state_d = ST_RESET_PLL;
               if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
            end else if (relock_req) begin
               state_d = ST_RESET_PLL;
            end
         end
         ST_FAIL: begin
            if (relock_req) begin
               state_d = ST_RESET_PLL;
               retry_d = '0;
            end
         end
         default: state_d = ST_RESET_PLL;
      endcase

      pcnt_d = (state_q == ST_RESET_PLL && state_d == ST_RESET_PLL) ? pcnt_q + 1'b1 : '0;
      tcnt_d = (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK) ? tcnt_q + 1'b1 : '0;
      scnt_d = (state_q == ST_STABILIZE && state_d == ST_STABILIZE) ? scnt_q + 1'b1 : '0;
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         lk_meta_q <= 1'b0;
         lk_s_q    <= 1'b0;
         state_q   <= ST_RESET_PLL;
         pcnt_q    <= '0;
         tcnt_q    <= '0;
         scnt_q    <= '0;
         retry_q   <= '0;
         lost_q    <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         fail_q    <= 1'b0;
      end else begin
         lk_meta_q <= pll_locked;
         lk_s_q    <= lk_meta_q;
         state_q   <= state_d;
         pcnt_q    <= pcnt_d;
         tcnt_q    <= tcnt_d;
         scnt_q    <= scnt_d;
         retry_q   <= retry_d;
         lost_q    <= lost_d;
         pll_rst_q <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
         sys_rst_q <= (state_d != ST_RUN);
         fail_q    <= (state_d == ST_FAIL);
      end
   end

   assign state         = state_q;
   assign retry_cnt     = retry_q;
   assign lock_lost_cnt = lost_q;
   assign pll_rst       = pll_rst_q;
   assign sys_rst       = sys_rst_q;
   assign fail          = fail_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters; edge counts are hand-derived.
module tb_pll_reset_sequencer;

`ifdef PLL_SEQ_GLITCH_FILTER_EN
   localparam int LOSS_LOW = 4;
`else
   localparam int LOSS_LOW = 1;
`endif

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_rst, sys_rst, fail;
   logic [2:0] state;
   logic [1:0] retry_cnt;
   logic [7:0] lock_lost_cnt;

   int checks = 0;
   int errors = 0;
   int exp_lost = 0;

   always #10 refclk = ~refclk;

   pll_reset_sequencer #(
      .RST_PULSE_CYCLES   (4),
      .LOCK_TIMEOUT_CYCLES(20),
      .LOCK_STABLE_CYCLES (8),
      .MAX_RETRIES        (2),
      .GLITCH_CYCLES      (4)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .relock_req   (relock_req),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .state        (state),
      .retry_cnt    (retry_cnt),
      .fail         (fail),
      .lock_lost_cnt(lock_lost_cnt)
   );

   task automatic chk_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic pulse_relock();
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
   endtask

   // Loss edge is n_low+2 after pll_locked first sampled low; re-lock reaches RUN 13 edges later.
   task automatic drop_lock(input int n_low);
      pll_locked = 1'b0;
      tick(n_low);
      pll_locked = 1'b1;
      tick(1);
      chk_eq("loss_pre_sys_rst", int'(sys_rst), 0);
      tick(1);
      exp_lost = (exp_lost == 255) ? 255 : exp_lost + 1;
      chk_eq("loss_sys_rst", int'(sys_rst), 1);
      chk_eq("loss_state", int'(state), 0);
      chk_eq("loss_cnt", int'(lock_lost_cnt), exp_lost);
      tick(13);
      chk_eq("relock_run", int'(state), 3);
   endtask

   initial begin
      tick(3);
      chk_eq("rst_state", int'(state), 0);
      chk_eq("rst_pll_rst", int'(pll_rst), 1);
      chk_eq("rst_sys_rst", int'(sys_rst), 1);
      chk_eq("rst_fail", int'(fail), 0);
      chk_eq("rst_retry", int'(retry_cnt), 0);
      chk_eq("rst_lost", int'(lock_lost_cnt), 0);

      // normal bring-up, lock raised 10 cycles after release
      rst = 1'b0;
      tick(3);
      chk_eq("bu_pulse_last", int'(pll_rst), 1);
      chk_eq("bu_state0", int'(state), 0);
      tick(1);
      chk_eq("bu_pulse_end", int'(pll_rst), 0);
      chk_eq("bu_state1", int'(state), 1);
      tick(6);
      pll_locked = 1'b1;
      tick(2);
      chk_eq("bu_sync_delay", int'(state), 1);
      tick(1);
      chk_eq("bu_state2", int'(state), 2);
      tick(7);
      chk_eq("bu_stab_hold", int'(state), 2);
      chk_eq("bu_stab_sys_rst", int'(sys_rst), 1);
      tick(1);
      chk_eq("bu_state3", int'(state), 3);
      chk_eq("bu_sys_rst", int'(sys_rst), 0);
      chk_eq("bu_retry", int'(retry_cnt), 0);
      chk_eq("bu_pll_rst", int'(pll_rst), 0);

      // relock_req in RUN restarts without counting a loss
      pulse_relock();
      chk_eq("rq_state", int'(state), 0);
      chk_eq("rq_sys_rst", int'(sys_rst), 1);
      chk_eq("rq_pll_rst", int'(pll_rst), 1);
      chk_eq("rq_lost", int'(lock_lost_cnt), 0);
      tick(12);
      chk_eq("rq_stab", int'(state), 2);
      tick(1);
      chk_eq("rq_run", int'(state), 3);

      // unstable lock during STABILIZE
      pulse_relock();
      tick(5);
      chk_eq("un_stab_entry", int'(state), 2);
      tick(4);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(1);
      chk_eq("un_still_stab", int'(state), 2);
      tick(1);
      chk_eq("un_back_wait", int'(state), 1);
      chk_eq("un_sys_rst", int'(sys_rst), 1);
      chk_eq("un_retry", int'(retry_cnt), 0);
      tick(1);
      chk_eq("un_restab", int'(state), 2);
      tick(7);
      chk_eq("un_stab_hold", int'(state), 2);
      chk_eq("un_stab_sys_rst", int'(sys_rst), 1);
      tick(1);
      chk_eq("un_run", int'(state), 3);
      chk_eq("un_run_sys_rst", int'(sys_rst), 0);

`ifdef PLL_SEQ_GLITCH_FILTER_EN
      pll_locked = 1'b0;
      tick(3);
      pll_locked = 1'b1;
      tick(4);
      chk_eq("gf_short_state", int'(state), 3);
      chk_eq("gf_short_sys_rst", int'(sys_rst), 0);
      chk_eq("gf_short_lost", int'(lock_lost_cnt), 0);
`endif

      // loss of lock in RUN, then saturation of the loss counter
      for (int i = 0; i < 300; i++) drop_lock(LOSS_LOW);
      chk_eq("sat_lost", int'(lock_lost_cnt), 255);

      // reset while in RUN, lock never comes back
      rst = 1'b1;
      pll_locked = 1'b0;
      tick(1);
      rst = 1'b0;
      chk_eq("rr_state", int'(state), 0);
      chk_eq("rr_pll_rst", int'(pll_rst), 1);
      chk_eq("rr_sys_rst", int'(sys_rst), 1);
      chk_eq("rr_lost", int'(lock_lost_cnt), 0);
      chk_eq("rr_retry", int'(retry_cnt), 0);
      tick(3);
      chk_eq("nl_pulse1", int'(pll_rst), 1);
      tick(1);
      chk_eq("nl_wait1", int'(state), 1);
      chk_eq("nl_pll_rst_lo", int'(pll_rst), 0);
      pulse_relock();
      chk_eq("nl_relock_ignored", int'(state), 1);
      tick(18);
      chk_eq("nl_wait1_end", int'(state), 1);
      chk_eq("nl_retry0", int'(retry_cnt), 0);
      tick(1);
      chk_eq("nl_retry1_state", int'(state), 0);
      chk_eq("nl_retry1", int'(retry_cnt), 1);
      chk_eq("nl_pulse2", int'(pll_rst), 1);
      tick(3);
      chk_eq("nl_pulse2_last", int'(pll_rst), 1);
      tick(1);
      chk_eq("nl_wait2", int'(state), 1);
      chk_eq("nl_pulse2_end", int'(pll_rst), 0);
      tick(19);
      chk_eq("nl_wait2_end", int'(state), 1);
      chk_eq("nl_wait2_retry", int'(retry_cnt), 1);
      tick(1);
      chk_eq("nl_fail_state", int'(state), 4);
      chk_eq("nl_fail", int'(fail), 1);
      chk_eq("nl_fail_pll_rst", int'(pll_rst), 1);
      chk_eq("nl_fail_sys_rst", int'(sys_rst), 1);
      chk_eq("nl_fail_retry", int'(retry_cnt), 2);
      tick(5);
      chk_eq("nl_fail_hold", int'(state), 4);
      pulse_relock();
      chk_eq("fr_state", int'(state), 0);
      chk_eq("fr_retry", int'(retry_cnt), 0);
      chk_eq("fr_fail", int'(fail), 0);

      // lock arrives on the same edge the timeout expires
      tick(21);
      pll_locked = 1'b1;
      tick(2);
      chk_eq("lw_pre", int'(state), 1);
      tick(1);
      chk_eq("lw_state", int'(state), 2);
      chk_eq("lw_retry", int'(retry_cnt), 0);

      // reset while in STABILIZE
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk_eq("rs_state", int'(state), 0);
      chk_eq("rs_pll_rst", int'(pll_rst), 1);
      chk_eq("rs_sys_rst", int'(sys_rst), 1);
      chk_eq("rs_fail", int'(fail), 0);
      chk_eq("rs_retry", int'(retry_cnt), 0);
      chk_eq("rs_lost", int'(lock_lost_cnt), 0);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
